// File: rtl/cpu_run_pkg.sv
// Shared types for the CPU run controller: run modes, stop causes and FSM states.
package cpu_run_pkg;

  typedef enum logic [1:0] {
    MODE_FREE  = 2'd0,
    MODE_MATCH = 2'd1,
    MODE_STEP  = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    CAUSE_NONE  = 2'd0,
    CAUSE_LIMIT = 2'd1,
    CAUSE_MATCH = 2'd2,
    CAUSE_ABORT = 2'd3
  } cause_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLD,
    ST_ARM,
    ST_RUN,
    ST_STEP_WAIT,
    ST_STEP_EXEC,
    ST_STOP
  } state_t;

  // The reserved encoding 3 runs as FREE.
  function automatic mode_t decode_mode(input logic [1:0] m);
    case (m)
      2'd1:    return MODE_MATCH;
      2'd2:    return MODE_STEP;
      default: return MODE_FREE;
    endcase
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_sat_counter.sv
// Width-parametrised up-counter that sticks at all-ones; clear wins over increment.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !(&count)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller for the CPU core: sequences reset/enable, runs FREE/MATCH/STEP
// modes with an optional cycle limit, and captures the core result at the stop.
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned CYC_W      = 32,
  parameter int unsigned RST_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              step,
  input  logic [1:0]        mode,
  input  logic [CYC_W-1:0]  max_cycles,
  input  logic [DATA_W-1:0] match_value,
  input  logic [DATA_W-1:0] cpu_result,
  output logic              cpu_reset_n,
  output logic              cpu_en,
  output logic              busy,
  output logic              done,
  output logic [1:0]        done_cause,
  output logic [CYC_W-1:0]  cycle_count,
  output logic [DATA_W-1:0] captured_result
);

  localparam int unsigned HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  mode_t             mode_q, mode_d;
  logic [CYC_W-1:0]  max_q, max_d, cnt_inc;
  logic [DATA_W-1:0] match_q, match_d, capt_d;
  cause_t            cause_q, cause_d, stop_cause;
  logic              rstn_d, en_d, busy_d, done_d;
  logic              cnt_clr, stop, limit_hit;

  sat_counter #(.W(CYC_W)) u_cycle_cnt (
    .clk   (clk),
    .rst   (reset),
    .clr   (cnt_clr),
    .inc   (cpu_en),
    .count (cycle_count)
  );

  // Limit compares against the value the counter takes at this edge.
  assign cnt_inc    = (&cycle_count) ? cycle_count : cycle_count + CYC_W'(1);
  assign limit_hit  = (max_q != '0) && (cnt_inc == max_q);
  assign done_cause = cause_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      hold_q          <= '0;
      mode_q          <= MODE_FREE;
      max_q           <= '0;
      match_q         <= '0;
      cause_q         <= CAUSE_NONE;
      cpu_reset_n     <= 1'b0;
      cpu_en          <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      captured_result <= '0;
    end else begin
      state_q         <= state_d;
      hold_q          <= hold_d;
      mode_q          <= mode_d;
      max_q           <= max_d;
      match_q         <= match_d;
      cause_q         <= cause_d;
      cpu_reset_n     <= rstn_d;
      cpu_en          <= en_d;
      busy            <= busy_d;
      done            <= done_d;
      captured_result <= capt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    mode_d     = mode_q;
    max_d      = max_q;
    match_d    = match_q;
    cause_d    = cause_q;
    rstn_d     = cpu_reset_n;
    en_d       = cpu_en;
    busy_d     = busy;
    done_d     = done;
    capt_d     = captured_result;
    cnt_clr    = 1'b0;
    stop       = 1'b0;
    stop_cause = CAUSE_NONE;

    case (state_q)
      ST_IDLE, ST_STOP: begin
        if (start) begin
          mode_d  = decode_mode(mode);
          max_d   = max_cycles;
          match_d = match_value;
          cnt_clr = 1'b1;
          cause_d = CAUSE_NONE;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          rstn_d  = 1'b0;
          en_d    = 1'b0;
          hold_d  = HOLD_W'(RST_CYCLES - 1);
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (abort) begin
          stop       = 1'b1;
          stop_cause = CAUSE_ABORT;
        end else if (hold_q == '0) begin
          rstn_d  = 1'b1;
          state_d = ST_ARM;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      ST_ARM: begin
        if (abort) begin
          stop       = 1'b1;
          stop_cause = CAUSE_ABORT;
        end else if (mode_q == MODE_STEP) begin
          state_d = ST_STEP_WAIT;
        end else begin
          en_d    = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          stop       = 1'b1;
          stop_cause = CAUSE_ABORT;
        end else if (mode_q == MODE_MATCH && cpu_result == match_q) begin
          stop       = 1'b1;
          stop_cause = CAUSE_MATCH;
        end else if (limit_hit) begin
          stop       = 1'b1;
          stop_cause = CAUSE_LIMIT;
        end
      end
      ST_STEP_WAIT: begin
        if (abort) begin
          stop       = 1'b1;
          stop_cause = CAUSE_ABORT;
        end else if (step) begin
          en_d    = 1'b1;
          state_d = ST_STEP_EXEC;
        end
      end
      ST_STEP_EXEC: begin
        en_d    = 1'b0;
        capt_d  = cpu_result;
        state_d = ST_STEP_WAIT;
        if (abort) begin
          stop       = 1'b1;
          stop_cause = CAUSE_ABORT;
        end else if (limit_hit) begin
          stop       = 1'b1;
          stop_cause = CAUSE_LIMIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // cpu_reset_n is left as-is so a stopped core stays inspectable.
    if (stop) begin
      en_d    = 1'b0;
      capt_d  = cpu_result;
      done_d  = 1'b1;
      busy_d  = 1'b0;
      cause_d = stop_cause;
      state_d = ST_STOP;
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: edge-timeline reference model plus
// directed literal checks and a randomized soak; a 4-bit instance covers saturation.
module tb_cpu_run_ctrl;

  localparam int unsigned R = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, abort = 1'b0, step = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [31:0] max_cycles = '0, match_value = '0, cpu_result;
  logic        cpu_reset_n, cpu_en, busy, done;
  logic [1:0]  done_cause;
  logic [31:0] cycle_count, captured_result;

  logic        s_start = 1'b0, s_abort = 1'b0;
  logic        s_rstn, s_en, s_busy, s_done;
  logic [1:0]  s_cause;
  logic [3:0]  s_count;
  logic [7:0]  s_capt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cpu_run_ctrl #(.DATA_W(32), .CYC_W(32), .RST_CYCLES(R)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .step(step),
    .mode(mode), .max_cycles(max_cycles), .match_value(match_value),
    .cpu_result(cpu_result), .cpu_reset_n(cpu_reset_n), .cpu_en(cpu_en),
    .busy(busy), .done(done), .done_cause(done_cause),
    .cycle_count(cycle_count), .captured_result(captured_result)
  );

  cpu_run_ctrl #(.DATA_W(8), .CYC_W(4), .RST_CYCLES(R)) u_small (
    .clk(clk), .reset(reset), .start(s_start), .abort(s_abort), .step(1'b0),
    .mode(2'd0), .max_cycles(4'd0), .match_value(8'd0),
    .cpu_result(8'h5A), .cpu_reset_n(s_rstn), .cpu_en(s_en),
    .busy(s_busy), .done(s_done), .done_cause(s_cause),
    .cycle_count(s_count), .captured_result(s_capt)
  );

  // Core stand-in: result counts enabled cycles, cleared while held in reset.
  logic [31:0] core_q = '0;
  always @(posedge clk) begin
    if (!cpu_reset_n) core_q <= '0;
    else if (cpu_en)  core_q <= core_q + 32'd1;
  end
  assign cpu_result = core_q;

  int en_cycles = 0;
  always @(posedge clk) if (cpu_en) en_cycles++;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: outputs expressed as functions of the edge index since start.
  bit     m_busy = 0, m_done = 0, m_rstn = 0, m_en = 0;
  int     m_cause = 0, m_mode = 0, m_rel = 0;
  longint m_count = 0, m_capt = 0, m_max = 0, m_match = 0;

  always @(posedge clk) begin
    bit stp;
    int cz;
    if (reset) begin
      m_busy = 0; m_done = 0; m_rstn = 0; m_en = 0;
      m_cause = 0; m_count = 0; m_capt = 0;
    end else if (!m_busy) begin
      if (start) begin
        m_mode  = (mode == 2'd3) ? 0 : int'(mode);
        m_max   = longint'(max_cycles);
        m_match = longint'(match_value);
        m_count = 0; m_done = 0; m_cause = 0;
        m_busy  = 1; m_rstn = 0; m_en = 0; m_rel = 0;
      end
    end else begin
      m_rel++;
      stp = 0; cz = 0;
      if (m_en) begin
        if (m_count != 64'hFFFF_FFFF) m_count++;
        if (abort) begin stp = 1; cz = 3; end
        else if (m_mode == 1 && longint'(cpu_result) == m_match) begin stp = 1; cz = 2; end
        else if (m_max != 0 && m_count == m_max) begin stp = 1; cz = 1; end
        if (m_mode == 2) m_capt = longint'(cpu_result);
      end else if (abort) begin
        stp = 1; cz = 3;
      end
      if (stp) begin
        m_en = 0; m_capt = longint'(cpu_result);
        m_done = 1; m_busy = 0; m_cause = cz;
      end else begin
        m_rstn = (m_rel >= int'(R));
        if (m_mode == 2) m_en = !m_en && step && (m_rel >= int'(R) + 2);
        else             m_en = (m_rel >= int'(R) + 1);
      end
    end
  end

  always begin
    @(posedge clk);
    #2;
    check("cpu_reset_n", cpu_reset_n, m_rstn);
    check("cpu_en", cpu_en, m_en);
    check("busy", busy, m_busy);
    check("done", done, m_done);
    check("done_cause", done_cause, m_cause);
    check("cycle_count", cycle_count, m_count);
    check("captured_result", captured_result, m_capt);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_start(input logic [1:0] md, input logic [31:0] mx, input logic [31:0] mv);
    mode = md; max_cycles = mx; match_value = mv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int i;
    i = 0;
    while (!done && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(name, done, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int base, guard;

    tick(3);
    check("rst_rstn", cpu_reset_n, 0);
    check("rst_en", cpu_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cause", done_cause, 0);
    check("rst_count", cycle_count, 0);
    check("rst_capt", captured_result, 0);
    reset = 1'b0;
    tick(2);

    // FREE, limit 5
    base = en_cycles;
    run_start(2'd0, 32'd5, 32'd0);
    check("free_hold0", cpu_reset_n, 0);
    tick(1);
    check("free_hold1", cpu_reset_n, 0);
    tick(1);
    check("free_arm_rstn", cpu_reset_n, 1);
    check("free_arm_en", cpu_en, 0);
    tick(1);
    check("free_first_en", cpu_en, 1);
    wait_done("free_done", 20);
    check("free_en_cycles", en_cycles - base, 5);
    check("free_cause", done_cause, 1);
    check("free_count", cycle_count, 5);
    tick(2);

    // MATCH on 42
    base = en_cycles;
    run_start(2'd1, 32'd0, 32'h0000_002A);
    wait_done("match_done", 100);
    check("match_cause", done_cause, 2);
    check("match_capt", captured_result, 42);
    check("match_count", cycle_count, 43);
    tick(5);
    check("match_en_cycles", en_cycles - base, 43);

    // STEP: three accepted pulses, one extra during the enabled cycle
    base = en_cycles;
    run_start(2'd2, 32'd0, 32'd0);
    tick(5);
    for (int i = 0; i < 3; i++) begin
      step = 1'b1;
      @(negedge clk);
      step = (i == 0);
      @(negedge clk);
      step = 1'b0;
      check("step_capt", captured_result, i);
      check("step_en_off", cpu_en, 0);
      tick(2);
    end
    check("step_en_cycles", en_cycles - base, 3);
    check("step_count", cycle_count, 3);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("step_abort_cause", done_cause, 3);
    tick(2);

    // FREE unlimited, abort on the 100th enabled cycle, ignored start while busy
    base = en_cycles;
    run_start(2'd0, 32'd0, 32'd0);
    guard = 0;
    while ((en_cycles - base) < 99 && guard < 300) begin
      start = (guard == 20);
      if (guard == 20) begin mode = 2'd2; max_cycles = 32'd3; end
      tick(1);
      guard++;
    end
    start = 1'b0; mode = 2'd0; max_cycles = '0;
    check("abort_reach99", en_cycles - base, 99);
    check("abort_busy", busy, 1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("abort_en", cpu_en, 0);
    check("abort_cause", done_cause, 3);
    check("abort_count", cycle_count, 100);
    tick(3);
    check("abort_en_cycles", en_cycles - base, 100);

    // Reset mid-run, then replay
    run_start(2'd0, 32'd0, 32'd0);
    tick(10);
    reset = 1'b1;
    #1;
    check("mid_rst_rstn", cpu_reset_n, 0);
    check("mid_rst_en", cpu_en, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cause", done_cause, 0);
    check("mid_rst_count", cycle_count, 0);
    check("mid_rst_capt", captured_result, 0);
    @(negedge clk);
    reset = 1'b0;
    tick(1);
    run_start(2'd0, 32'd0, 32'd0);
    check("replay_hold0", cpu_reset_n, 0);
    tick(1);
    check("replay_hold1", cpu_reset_n, 0);
    tick(1);
    check("replay_arm", cpu_reset_n, 1);
    check("replay_arm_en", cpu_en, 0);
    tick(1);
    check("replay_en", cpu_en, 1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    tick(2);

    // 4-bit counter saturation
    s_start = 1'b1;
    tick(1);
    s_start = 1'b0;
    tick(25);
    check("sat_count", s_count, 15);
    check("sat_en", s_en, 1);
    check("sat_busy", s_busy, 1);
    tick(10);
    check("sat_hold", s_count, 15);
    s_abort = 1'b1;
    tick(1);
    s_abort = 1'b0;
    check("sat_cause", s_cause, 3);
    check("sat_done", s_done, 1);
    check("sat_final", s_count, 15);
    check("sat_capt", s_capt, 8'h5A);

    // Randomized soak
    for (int c = 0; c < 3000; c++) begin
      start       = ($urandom_range(0, 19) == 0);
      abort       = ($urandom_range(0, 79) == 0);
      step        = ($urandom_range(0, 2) == 0);
      mode        = 2'($urandom_range(0, 3));
      max_cycles  = 32'($urandom_range(0, 30));
      match_value = 32'($urandom_range(0, 40));
      reset       = ($urandom_range(0, 799) == 0);
      tick(1);
    end
    start = 1'b0; abort = 1'b0; step = 1'b0; reset = 1'b0;
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
